// File: rtl/lcd_responder.sv
// HD44780-style LCD responder: synchronizes the controller's E/RS/RW/data bus,
// decodes instructions and data transfers into a 32-entry DDRAM with busy timing.
module lcd_responder #(
   parameter int BUSY_CYC  = 40,
   parameter int CLEAR_CYC = 64
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic [7:0] lcd_data_in,
   input  logic       lcd_enable,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   output logic [7:0] lcd_data_out,
   output logic       lcd_data_oe,
   input  logic [4:0] char_addr,
   output logic [7:0] char_data,
   output logic       display_on,
   output logic       cmd_dropped
);

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [5:0]         clr_q, clr_d;
   logic [6:0]         ac_q, ac_d;
   logic               id_q, id_d;
   logic               disp_q, disp_d;
   logic               drop_q, drop_d;
   logic [7:0]         ddram [32];
   logic [7:0]         char_q;

   logic               en_p0, en_p1, en_p2;
   logic               rs_p0, rs_p1, rw_p0, rw_p1;
   logic [7:0]         dat_p0, dat_p1;
   logic               rs_l, rw_l;
   logic [7:0]         dat_l;

   logic               fall;
   logic               wr_en;
   logic [4:0]         wr_idx;
   logic [7:0]         wr_dat;
   logic               busy;

   // Two-line address wrap: 0x27<->0x40 and 0x67<->0x00; other values are plain 7-bit steps.
   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
      logic [6:0] r;
      if (inc) begin
         if (ac == 7'h27)      r = 7'h40;
         else if (ac == 7'h67) r = 7'h00;
         else                  r = ac + 7'd1;
      end else begin
         if (ac == 7'h00)      r = 7'h67;
         else if (ac == 7'h40) r = 7'h27;
         else                  r = ac - 7'd1;
      end
      return r;
   endfunction

   function automatic logic ac_visible(input logic [6:0] ac);
      return (ac[6:4] == 3'b000) || (ac[6:4] == 3'b100);
   endfunction

   function automatic logic [4:0] ac_index(input logic [6:0] ac);
      return {ac[6], ac[3:0]};
   endfunction

   // Bus synchronizer (p0/p1), edge history (p2) and capture of the last E-high cycle.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         en_p0  <= 1'b0; en_p1 <= 1'b0; en_p2 <= 1'b0;
         rs_p0  <= 1'b0; rs_p1 <= 1'b0;
         rw_p0  <= 1'b0; rw_p1 <= 1'b0;
         dat_p0 <= 8'h00; dat_p1 <= 8'h00;
         rs_l   <= 1'b0; rw_l <= 1'b0; dat_l <= 8'h00;
      end else begin
         en_p0  <= lcd_enable;   en_p1  <= en_p0;  en_p2 <= en_p1;
         rs_p0  <= lcd_rs;       rs_p1  <= rs_p0;
         rw_p0  <= lcd_rw;       rw_p1  <= rw_p0;
         dat_p0 <= lcd_data_in;  dat_p1 <= dat_p0;
         if (en_p1) begin
            rs_l  <= rs_p1;
            rw_l  <= rw_p1;
            dat_l <= dat_p1;
         end
      end
   end

   assign fall = en_p2 & ~en_p1;
   assign busy = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_d   = clr_q;
      ac_d    = ac_q;
      id_d    = id_q;
      disp_d  = disp_q;
      drop_d  = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = 5'd0;
      wr_dat  = 8'h00;

      if (state_q == CLEAR && !clr_q[5]) begin
         wr_en  = 1'b1;
         wr_idx = clr_q[4:0];
         wr_dat = 8'h20;
         clr_d  = clr_q + 6'd1;
      end
      if (state_q != IDLE) begin
         if (cnt_q == '0) state_d = IDLE;
         else             cnt_d   = cnt_q - 1'b1;
      end

      if (fall) begin
         if (rw_l) begin
            if (rs_l) ac_d = ac_step(ac_q, id_q);
         end else if (state_q != IDLE) begin
            drop_d = 1'b1;
         end else begin
            state_d = EXEC;
            cnt_d   = CNT_W'(BUSY_CYC - 1);
            if (rs_l) begin
               if (ac_visible(ac_q)) begin
                  wr_en  = 1'b1;
                  wr_idx = ac_index(ac_q);
                  wr_dat = dat_l;
               end
               ac_d = ac_step(ac_q, id_q);
            end else begin
               casez (dat_l)
                  8'b1???????: ac_d = dat_l[6:0];
                  8'b0001????: if (!dat_l[3]) ac_d = ac_step(ac_q, dat_l[2]);
                  8'b00001???: disp_d = dat_l[2];
                  8'b000001??: id_d = dat_l[1];
                  8'b0000001?: ac_d = 7'h00;
                  8'b00000001: begin
                     ac_d    = 7'h00;
                     id_d    = 1'b1;
                     state_d = CLEAR;
                     cnt_d   = CNT_W'(CLEAR_CYC - 1);
                     clr_d   = 6'd0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Control state, DDRAM and display-side read port.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         clr_q   <= 6'd0;
         ac_q    <= 7'h00;
         id_q    <= 1'b1;
         disp_q  <= 1'b0;
         drop_q  <= 1'b0;
         char_q  <= 8'h20;
         for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clr_q   <= clr_d;
         ac_q    <= ac_d;
         id_q    <= id_d;
         disp_q  <= disp_d;
         drop_q  <= drop_d;
         char_q  <= ddram[char_addr];
         if (wr_en) ddram[wr_idx] <= wr_dat;
      end
   end

   assign lcd_data_oe  = en_p1 & rw_p1;
   assign lcd_data_out = !lcd_data_oe ? 8'h00 :
                         !rs_p1       ? {busy, ac_q} :
                         ac_visible(ac_q) ? ddram[ac_index(ac_q)] : 8'h20;
   assign char_data    = char_q;
   assign display_on   = disp_q;
   assign cmd_dropped  = drop_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: table of bus transfers with expected read-back,
// plus hand-written clear, busy-drop and reset-abort sequences.
module tb_lcd_responder;

   localparam int BUSY_CYC  = 40;
   localparam int CLEAR_CYC = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] lcd_data_in = 8'h00;
   logic       lcd_enable = 1'b0;
   logic       lcd_rs = 1'b0;
   logic       lcd_rw = 1'b0;
   logic [7:0] lcd_data_out;
   logic       lcd_data_oe;
   logic [4:0] char_addr = 5'd0;
   logic [7:0] char_data;
   logic       display_on;
   logic       cmd_dropped;

   int checks = 0;
   int errors = 0;
   int drop_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (cmd_dropped) drop_cnt <= drop_cnt + 1;

   lcd_responder #(.BUSY_CYC(BUSY_CYC), .CLEAR_CYC(CLEAR_CYC)) dut (
      .clk_clk      (clk),
      .reset_reset_n(rst_n),
      .lcd_data_in  (lcd_data_in),
      .lcd_enable   (lcd_enable),
      .lcd_rs       (lcd_rs),
      .lcd_rw       (lcd_rw),
      .lcd_data_out (lcd_data_out),
      .lcd_data_oe  (lcd_data_oe),
      .char_addr    (char_addr),
      .char_data    (char_data),
      .display_on   (display_on),
      .cmd_dropped  (cmd_dropped)
   );

   typedef struct {
      logic       rd;
      logic       rs;
      logic [7:0] d;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl [33];

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %02h expected %02h", nm, act, exp);
      end
   endtask

   // One E pulse; rd holds lcd_data_out sampled while E is high.
   task automatic pulse(input logic rs, input logic rw, input logic [7:0] d, output logic [7:0] rd);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_enable = 1'b1;
      repeat (4) @(negedge clk);
      rd = lcd_data_out;
      lcd_enable = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wr_wait(input logic rs, input logic [7:0] d);
      logic [7:0] junk;
      pulse(rs, 1'b0, d, junk);
      repeat (BUSY_CYC + 2) @(negedge clk);
   endtask

   task automatic char_rd(input logic [4:0] idx, output logic [7:0] v);
      @(negedge clk);
      char_addr = idx;
      @(negedge clk);
      v = char_data;
   endtask

   initial begin
      logic [7:0] v;
      int n80;
      int d0;

      tbl[0]  = '{1'b0, 1'b0, 8'h80, 8'h00};
      tbl[1]  = '{1'b0, 1'b1, 8'h41, 8'h00};
      tbl[2]  = '{1'b0, 1'b1, 8'h42, 8'h00};
      tbl[3]  = '{1'b1, 1'b0, 8'h00, 8'h02};
      tbl[4]  = '{1'b0, 1'b0, 8'hA7, 8'h00};
      tbl[5]  = '{1'b1, 1'b0, 8'h00, 8'h27};
      tbl[6]  = '{1'b0, 1'b1, 8'h5A, 8'h00};
      tbl[7]  = '{1'b1, 1'b0, 8'h00, 8'h40};
      tbl[8]  = '{1'b0, 1'b0, 8'h80, 8'h00};
      tbl[9]  = '{1'b1, 1'b1, 8'h00, 8'h41};
      tbl[10] = '{1'b1, 1'b0, 8'h00, 8'h01};
      tbl[11] = '{1'b1, 1'b1, 8'h00, 8'h42};
      tbl[12] = '{1'b1, 1'b1, 8'h00, 8'h20};
      tbl[13] = '{1'b1, 1'b0, 8'h00, 8'h03};
      tbl[14] = '{1'b0, 1'b0, 8'h10, 8'h00};
      tbl[15] = '{1'b1, 1'b0, 8'h00, 8'h02};
      tbl[16] = '{1'b0, 1'b0, 8'h14, 8'h00};
      tbl[17] = '{1'b1, 1'b0, 8'h00, 8'h03};
      tbl[18] = '{1'b0, 1'b0, 8'h18, 8'h00};
      tbl[19] = '{1'b1, 1'b0, 8'h00, 8'h03};
      tbl[20] = '{1'b0, 1'b0, 8'h0C, 8'h00};
      tbl[21] = '{1'b0, 1'b0, 8'h02, 8'h00};
      tbl[22] = '{1'b1, 1'b0, 8'h00, 8'h00};
      tbl[23] = '{1'b0, 1'b0, 8'h04, 8'h00};
      tbl[24] = '{1'b0, 1'b0, 8'hC0, 8'h00};
      tbl[25] = '{1'b0, 1'b1, 8'h44, 8'h00};
      tbl[26] = '{1'b1, 1'b0, 8'h00, 8'h27};
      tbl[27] = '{1'b0, 1'b0, 8'h80, 8'h00};
      tbl[28] = '{1'b0, 1'b1, 8'h33, 8'h00};
      tbl[29] = '{1'b1, 1'b0, 8'h00, 8'h67};
      tbl[30] = '{1'b0, 1'b0, 8'h06, 8'h00};
      tbl[31] = '{1'b0, 1'b1, 8'h77, 8'h00};
      tbl[32] = '{1'b1, 1'b0, 8'h00, 8'h00};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_oe", {7'd0, lcd_data_oe}, 8'h00);
      check("rst_dout", lcd_data_out, 8'h00);
      check("rst_char", char_data, 8'h20);
      check("rst_disp", {7'd0, display_on}, 8'h00);
      check("rst_drop", {7'd0, cmd_dropped}, 8'h00);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      pulse(1'b0, 1'b1, 8'h00, v);
      check("rst_status", v, 8'h00);

      for (int i = 0; i < 33; i++) begin
         if (tbl[i].rd) begin
            pulse(tbl[i].rs, 1'b1, tbl[i].d, v);
            check($sformatf("vec%0d_read", i), v, tbl[i].exp);
         end else begin
            wr_wait(tbl[i].rs, tbl[i].d);
         end
      end
      check("disp_on", {7'd0, display_on}, 8'h01);
      char_rd(5'd0, v);  check("char0", v, 8'h33);
      char_rd(5'd1, v);  check("char1", v, 8'h42);
      char_rd(5'd2, v);  check("char2", v, 8'h20);
      char_rd(5'd15, v); check("char15", v, 8'h20);
      char_rd(5'd16, v); check("char16", v, 8'h44);
      char_rd(5'd17, v); check("char17", v, 8'h20);
      check("no_drop_yet", 8'(drop_cnt), 8'h00);

      // Data write issued while the preceding instruction is still executing
      d0 = drop_cnt;
      pulse(1'b0, 1'b0, 8'h08, v);
      repeat (2) @(negedge clk);
      pulse(1'b1, 1'b0, 8'h99, v);
      repeat (BUSY_CYC + 2) @(negedge clk);
      check("drop_pulses", 8'(drop_cnt - d0), 8'h01);
      check("drop_disp_off", {7'd0, display_on}, 8'h00);
      char_rd(5'd0, v); check("drop_char0", v, 8'h33);
      pulse(1'b0, 1'b1, 8'h00, v);
      check("drop_ac", v, 8'h00);

      // Clear display: status held readable across the whole busy window
      wr_wait(1'b0, 8'h85);
      @(negedge clk);
      lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data_in = 8'h01; lcd_enable = 1'b1;
      repeat (4) @(negedge clk);
      lcd_enable = 1'b0;
      @(negedge clk);
      lcd_rw = 1'b1; lcd_enable = 1'b1;
      n80 = 0;
      for (int c = 0; c < CLEAR_CYC + 20; c++) begin
         @(negedge clk);
         if (lcd_data_oe && lcd_data_out == 8'h80) n80++;
      end
      check("clear_busy_cycles", 8'(n80), 8'(CLEAR_CYC));
      check("clear_status_after", lcd_data_out, 8'h00);
      lcd_enable = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 32; k++) begin
         char_rd(5'(k), v);
         check($sformatf("clear_char%0d", k), v, 8'h20);
      end

      // Reset 10 cycles into a clear, with E held high through release
      wr_wait(1'b0, 8'h0C);
      wr_wait(1'b1, 8'h61);
      check("pre_reset_disp", {7'd0, display_on}, 8'h01);
      pulse(1'b0, 1'b0, 8'h01, v);
      repeat (7) @(negedge clk);
      lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data_in = 8'h00; lcd_enable = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_disp", {7'd0, display_on}, 8'h00);
      repeat (5) @(negedge clk);
      lcd_rw = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_oe", {7'd0, lcd_data_oe}, 8'h01);
      check("abort_status", lcd_data_out, 8'h00);
      lcd_enable = 1'b0;
      repeat (3) @(negedge clk);
      char_rd(5'd0, v); check("abort_char0", v, 8'h20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end

endmodule
